// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sub_pkg;

  // Default operand width in bits.
  localparam int DEF_WIDTH = 8;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_bitcell.sv
// One-bit full subtractor cell: d = x - y - bi, bo is the borrow out.
// Latency: combinational.
// Backpressure: none.
module sub_bitcell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), borrow_out = a < b + bin.
// Latency: start sampled at edge S -> done high for the one cycle after edge S+WIDTH.
// Backpressure: none; start is ignored while busy, result holds until the next accepted start.
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_bo;

  // The only arithmetic on operand bits: one cell fed by the shifter LSBs.
  sub_bitcell u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (brw),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // Controller: capture on start, one bit per RUN cycle LSB first, one-cycle done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          brw  <= cell_bo;
          // Each new bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
          diff <= {cell_d, diff[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            borrow_out <= cell_bo;
            done       <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl at WIDTH=8.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;

  int checks = 0;
  int errors = 0;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  // Reference: 9-bit two's complement subtraction; bit 8 is the borrow.
  function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic bi);
    return {1'b0, x} - {1'b0, y} - {8'd0, bi};
  endfunction

  // Present operands with start for one cycle; returns #1 after the sampling edge.
  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic biv);
    @(posedge clk); #1;
    a = av; b = bv; bin = biv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
  endtask

  // Counts edges since the edge after which start was raised; returns #1 into the done cycle.
  task automatic wait_done(input int first, output int cyc, output bit to);
    cyc = first;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    to = !done;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff: got %h expected 00", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b expected 0", borrow_out); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int cyc; bit to;
    logic [7:0] hold;
    launch(8'h05, 8'h03, 1'b0);
    wait_done(1, cyc, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
    checks++; if (cyc !== 9) begin errors++; $display("FAIL basic_latency: got %0d expected 9", cyc); end
    checks++; if (diff !== 8'h02) begin errors++; $display("FAIL basic_diff: got %h expected 02", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL basic_borrow: got %b expected 0", borrow_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done: got %b expected 1", busy); end
    hold = diff;
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
      checks++; if (diff !== 8'h02) begin errors++; $display("FAIL basic_hold: got %h expected %h", diff, hold); end
    end
  endtask

  task automatic test_corners;
    logic [7:0] av [2] = '{8'h00, 8'hFF};
    logic [7:0] bv [2] = '{8'h01, 8'hFF};
    logic       iv [2] = '{1'b0, 1'b1};
    int cyc; bit to;
    for (int i = 0; i < 2; i++) begin
      launch(av[i], bv[i], iv[i]);
      wait_done(1, cyc, to);
      checks++; if (to) begin errors++; $display("FAIL corner_timeout%0d: got no done expected done", i); end
      checks++; if (diff !== 8'hFF) begin errors++; $display("FAIL corner_diff%0d: got %h expected ff", i, diff); end
      checks++; if (borrow_out !== 1'b1) begin errors++; $display("FAIL corner_borrow%0d: got %b expected 1", i, borrow_out); end
    end
  endtask

  task automatic test_start_held;
    int cyc = 0;
    int pulses = 0;
    logic [8:0] exp;
    exp = ref_sub(8'hA7, 8'h3C, 1'b1);
    @(posedge clk); #1;
    a = 8'hA7; b = 8'h3C; bin = 1'b1; start = 1'b1;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_busy cycle %0d: got %b expected 1", cyc, busy); end
    end
    start = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL held_timeout: got no done expected done"); end
    checks++; if (diff !== exp[7:0]) begin errors++; $display("FAIL held_diff: got %h expected %h", diff, exp[7:0]); end
    checks++; if (borrow_out !== exp[8]) begin errors++; $display("FAIL held_borrow: got %b expected %b", borrow_out, exp[8]); end
    if (done) pulses++;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL held_pulses: got %0d expected 1", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_idle: got %b expected 0", busy); end
  endtask

  task automatic test_mid_reset;
    int cyc; bit to;
    launch(8'h3C, 8'h11, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL midrst_diff: got %h expected 00", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL midrst_borrow: got %b expected 0", borrow_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_accept: got %b expected 1", busy); end
    wait_done(1, cyc, to);
    checks++; if (to) begin errors++; $display("FAIL midrst_timeout: got no done expected done"); end
    checks++; if (diff !== 8'h7F) begin errors++; $display("FAIL midrst_diff2: got %h expected 7f", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL midrst_borrow2: got %b expected 0", borrow_out); end
  endtask

  task automatic test_back_to_back;
    int cyc; bit to;
    logic [8:0] e1, e2;
    e1 = ref_sub(8'h5A, 8'h3C, 1'b0);
    e2 = ref_sub(8'h10, 8'h20, 1'b1);
    launch(8'h5A, 8'h3C, 1'b0);
    wait_done(1, cyc, to);
    checks++; if ({borrow_out, diff} !== e1) begin errors++; $display("FAIL b2b_first: got %h expected %h", {borrow_out, diff}, e1); end
    @(posedge clk); #1;
    a = 8'h10; b = 8'h20; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2, cyc, to);
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout: got no done expected done"); end
    checks++; if (cyc !== 10) begin errors++; $display("FAIL b2b_spacing: got %0d expected 10", cyc); end
    checks++; if ({borrow_out, diff} !== e2) begin errors++; $display("FAIL b2b_second: got %h expected %h", {borrow_out, diff}, e2); end
  endtask

  task automatic test_random;
    int cyc; bit to;
    logic [7:0] av, bv;
    logic       iv;
    logic [8:0] exp;
    logic [8:0] prev;
    bit         have_prev = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      if (have_prev) begin
        checks++; if ({borrow_out, diff} !== prev) begin errors++; $display("FAIL rand_hold %0d: got %h expected %h", i, {borrow_out, diff}, prev); end
      end
      av = 8'($urandom); bv = 8'($urandom); iv = 1'($urandom);
      exp = ref_sub(av, bv, iv);
      launch(av, bv, iv);
      wait_done(1, cyc, to);
      checks++;
      if (to || {borrow_out, diff} !== exp) begin
        errors++;
        $display("FAIL rand_op %0d: a=%h b=%h bin=%b got %h expected %h", i, av, bv, iv, {borrow_out, diff}, exp);
      end
      prev = exp;
      have_prev = 1'b1;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_corners;
    test_start_held;
    test_mid_reset;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
